// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle ARM control unit.
// Holds the state enum, condition/cmd codes, mux-select encodings and the ALU decode helper.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Unrecognised commands fall back to ADD and still write the register file.
    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: alu_decode = ALU_ADD;
            CMD_SUB: alu_decode = ALU_SUB;
            CMD_CMP: alu_decode = ALU_SUB;
            CMD_AND: alu_decode = ALU_AND;
            CMD_ORR: alu_decode = ALU_ORR;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_fsm_cond_unit.sv
// NZCV flag register and condition-field evaluation.
// N,Z load on every flag update; C,V only load for arithmetic (ADD/SUB class) operations.
module cond_unit
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       flag_update,
    input  logic       arith,
    output logic       cond_ex,
    output logic [3:0] flags
);

    logic flag_we_nz;
    logic flag_we_cv;
    logic n, z, c, v;

    assign flag_we_nz = flag_update;
    assign flag_we_cv = flag_update & arith;
    assign {n, z, c, v} = flags;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= 4'b0000;
        end else begin
            if (flag_we_nz) flags[3:2] <= alu_flags[3:2];
            if (flag_we_cv) flags[1:0] <= alu_flags[1:0];
        end
    end

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle ARM main controller: state sequencing, Moore output decode and condition gating.
//   state    | meaning
//   FETCH    | read instruction at PC, PC <= PC+4
//   DECODE   | read registers, latch condition result
//   MEMADR   | compute load/store address
//   MEMREAD  | read data memory at ALUOut
//   MEMWB    | write loaded data to register file
//   MEMWRITE | write data memory at ALUOut
//   EXECR    | ALU op with register operand
//   EXECI    | ALU op with immediate operand
//   ALUWB    | write ALU result to register file
//   BRANCH   | PC <= branch target
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTL_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          cond,
    input  logic [1:0]          op,
    input  logic [5:0]          funct,
    input  logic [3:0]          alu_flags,
    output logic                pc_write,
    output logic                adr_src,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          result_src,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic [3:0]          flags
);

    state_t     state_q;
    state_t     state_d;
    logic       cond_ex;
    logic       cond_ex_q;
    logic [1:0] alu_op;
    logic       arith;
    logic       no_write;
    logic       flag_update;

    assign alu_op      = alu_decode(funct[4:1]);
    assign arith       = (alu_op == ALU_ADD) || (alu_op == ALU_SUB);
    assign no_write    = (funct[4:1] == CMD_CMP);
    assign flag_update = ((state_q == EXECR) || (state_q == EXECI)) & funct[0] & cond_ex_q;

    cond_unit u_cond (
        .clk         (clk),
        .reset       (reset),
        .cond        (cond),
        .alu_flags   (alu_flags),
        .flag_update (flag_update),
        .arith       (arith),
        .cond_ex     (cond_ex),
        .flags       (flags)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            cond_ex_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) cond_ex_q <= cond_ex;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (op)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = funct[5] ? EXECI : EXECR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD: state_d = MEMWB;
            EXECR:   state_d = ALUWB;
            EXECI:   state_d = ALUWB;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        result_src  = RES_ALUOUT;
        alu_control = '0;
        case (state_q)
            FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = 1'b1;
                pc_write   = 1'b1;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
            end
            MEMADR:  alu_src_b = SRCB_IMM;
            MEMREAD: adr_src = 1'b1;
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = cond_ex_q;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = cond_ex_q;
            end
            EXECR: begin
                alu_src_b   = SRCB_REG;
                alu_control = ALUCTL_W'(alu_op);
            end
            EXECI: begin
                alu_src_b   = SRCB_IMM;
                alu_control = ALUCTL_W'(alu_op);
            end
            ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = cond_ex_q & ~no_write;
            end
            BRANCH: begin
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALURESULT;
                pc_write   = cond_ex_q;
            end
            default: ;
        endcase
        // Strobes must be dead the instant reset asserts, even though FETCH drives them high.
        if (!reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed instruction table, random instruction
// stream against a per-instruction-class reference model, and reset corner cases.
module tb_mc_control_fsm;

    logic       clk;
    logic       reset;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] alu_flags;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
    logic [1:0] alu_src_b, result_src, alu_control;
    logic [3:0] flags;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] mflags;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_control;
        logic [3:0] flags;
    } out_t;

    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] cond;
        logic [3:0] afl;
        int         rw;
        int         mw;
        int         pw;
        logic [3:0] fl;
    } vec_t;

    vec_t tbl[12];

    mc_control_fsm #(.ALUCTL_W(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .cond        (cond),
        .op          (op),
        .funct       (funct),
        .alu_flags   (alu_flags),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .alu_control (alu_control),
        .flags       (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] observed();
        return {pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a,
                alu_src_b, result_src, alu_control, flags};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ARM condition rule: even codes test a base predicate, odd codes invert it.
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? ~base : base;
    endfunction

    function automatic logic [1:0] ref_aluctl(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 2'b00;
            4'b0010: return 2'b01;
            4'b1010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic out_t reset_pattern();
        out_t e;
        e = '0;
        e.alu_src_a  = 1'b1;
        e.alu_src_b  = 2'b10;
        e.result_src = 2'b10;
        return e;
    endfunction

    // Runs one instruction for its architectural latency, comparing every cycle.
    task automatic run_instr(input logic [1:0] i_op, input logic [5:0] i_funct,
                             input logic [3:0] i_cond, input logic [3:0] ex_flags,
                             output int n_rw, output int n_mw, output int n_pw);
        int   ncyc;
        logic ce;
        out_t e;
        logic [1:0] actl;
        n_rw = 0; n_mw = 0; n_pw = 0; ce = 1'b0;
        op = i_op; funct = i_funct; cond = i_cond;
        actl = ref_aluctl(i_funct[4:1]);
        case (i_op)
            2'b01:   ncyc = i_funct[0] ? 5 : 4;
            2'b00:   ncyc = 4;
            2'b10:   ncyc = 3;
            default: ncyc = 2;
        endcase
        for (int k = 0; k < ncyc; k++) begin
            alu_flags = (k == 2 && i_op == 2'b00) ? ex_flags : 4'($urandom);
            if (k == 1) ce = cond_holds(i_cond, mflags);
            e = '0;
            e.flags = mflags;
            if (k == 0) begin
                e = reset_pattern();
                e.flags = mflags;
                e.pc_write = 1'b1;
                e.ir_write = 1'b1;
            end else if (k == 1) begin
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
            end else begin
                case (i_op)
                    2'b01: begin
                        if (k == 2) e.alu_src_b = 2'b01;
                        else if (k == 3) begin
                            e.adr_src = 1'b1;
                            e.mem_write = ~i_funct[0] & ce;
                        end else begin
                            e.result_src = 2'b01;
                            e.reg_write = ce;
                        end
                    end
                    2'b00: begin
                        if (k == 2) begin
                            e.alu_src_b = i_funct[5] ? 2'b01 : 2'b00;
                            e.alu_control = actl;
                        end else e.reg_write = ce & (i_funct[4:1] != 4'b1010);
                    end
                    default: begin
                        e.alu_src_b = 2'b01; e.result_src = 2'b10; e.pc_write = ce;
                    end
                endcase
            end
            @(negedge clk);
            check($sformatf("op%b_f%b_c%b_cyc%0d", i_op, i_funct, i_cond, k), observed(), e);
            if (k > 0) begin
                n_rw += int'(reg_write);
                n_mw += int'(mem_write);
                n_pw += int'(pc_write);
            end
            @(posedge clk);
            #1;
            if (k == 2 && i_op == 2'b00 && i_funct[0] && ce) begin
                mflags[3:2] = ex_flags[3:2];
                if (actl == 2'b00 || actl == 2'b01) mflags[1:0] = ex_flags[1:0];
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rw, mw, pw;
        tbl[0]  = '{2'b01, 6'b011001, 4'b1110, 4'b0000, 1, 0, 0, 4'b0000}; // LDR AL
        tbl[1]  = '{2'b01, 6'b011000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0000}; // STR EQ, Z=0
        tbl[2]  = '{2'b00, 6'b000101, 4'b1110, 4'b0110, 1, 0, 0, 4'b0110}; // SUBS
        tbl[3]  = '{2'b01, 6'b011000, 4'b0000, 4'b0000, 0, 1, 0, 4'b0110}; // STR EQ, Z=1
        tbl[4]  = '{2'b00, 6'b000001, 4'b1110, 4'b1011, 1, 0, 0, 4'b1010}; // ANDS holds C,V
        tbl[5]  = '{2'b00, 6'b110101, 4'b1110, 4'b0100, 0, 0, 0, 4'b0100}; // CMP imm
        tbl[6]  = '{2'b10, 6'b000000, 4'b0001, 4'b0000, 0, 0, 0, 4'b0100}; // BNE, Z=1
        tbl[7]  = '{2'b00, 6'b110101, 4'b1110, 4'b0010, 0, 0, 0, 4'b0010}; // CMP imm
        tbl[8]  = '{2'b10, 6'b000000, 4'b0001, 4'b0000, 0, 0, 1, 4'b0010}; // BNE, Z=0
        tbl[9]  = '{2'b11, 6'b000000, 4'b1110, 4'b0000, 0, 0, 0, 4'b0010}; // undefined
        tbl[10] = '{2'b00, 6'b011000, 4'b1110, 4'b1111, 1, 0, 0, 4'b0010}; // ORR, no S
        tbl[11] = '{2'b00, 6'b001001, 4'b1111, 4'b1111, 0, 0, 0, 4'b0010}; // ADDS never

        reset = 1'b1; cond = 4'b1110; op = 2'b11; funct = '0; alu_flags = '0;
        mflags = 4'b0000;
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold_%0d", i), observed(), reset_pattern());
        end
        @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_instr(tbl[i].op, tbl[i].funct, tbl[i].cond, tbl[i].afl, rw, mw, pw);
            check($sformatf("tbl%0d_reg_write_pulses", i), 16'(rw), 16'(tbl[i].rw));
            check($sformatf("tbl%0d_mem_write_pulses", i), 16'(mw), 16'(tbl[i].mw));
            check($sformatf("tbl%0d_pc_write_pulses", i), 16'(pw), 16'(tbl[i].pw));
            check($sformatf("tbl%0d_flags", i), 16'(flags), 16'(tbl[i].fl));
            check($sformatf("tbl%0d_back_to_fetch", i), 16'(ir_write), 16'd1);
        end

        for (int i = 0; i < 300; i++) begin
            logic [3:0] rc;
            rc = ($urandom_range(0, 1) == 0) ? 4'b1110 : 4'($urandom);
            run_instr(2'($urandom), 6'($urandom), rc, 4'($urandom), rw, mw, pw);
        end

        // Reset in the middle of an LDR's MEMREAD cycle.
        op = 2'b01; funct = 6'b011001; cond = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            alu_flags = 4'($urandom);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("midreset_in_memread_adr_src", 16'(adr_src), 16'd1);
        #1 reset = 1'b0;
        #1 check("midreset_immediate", observed(), reset_pattern());
        mflags = 4'b0000;
        op = 2'b11;
        rw = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("midreset_hold_%0d", k), observed(), reset_pattern());
            rw += int'(reg_write);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            int r2, m2, p2;
            run_instr(2'b11, 6'b011001, 4'b1110, 4'b0000, r2, m2, p2);
            rw += r2;
        end
        check("midreset_no_reg_write", 16'(rw), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control unit for the multi-cycle ARM datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the select lines of the datapath's 2:1 and 3:1 muxes (address, ALU operands, result), the ALU command and all write strobes.
- Holds the NZCV flag register and evaluates the condition field to gate the architectural writes.

Parameters:
- ALUCTL_W, 2, width of alu_control.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- cond  input  4  instruction condition field, Instr[31:28].
- op  input  2  instruction class, Instr[27:26].
- funct  input  6  Instr[25:20]: [5]=I (immediate), [4:1]=cmd, [0]=S/L.
- alu_flags  input  4  NZCV from the ALU, current cycle.
- pc_write  output  1  PC register enable.
- adr_src  output  1  memory address mux: 0=PC, 1=ALUOut.
- mem_write  output  1  data memory write strobe.
- ir_write  output  1  instruction register enable.
- reg_write  output  1  register file write strobe.
- alu_src_a  output  1  0=register A, 1=PC.
- alu_src_b  output  2  00=register B, 01=ExtImm, 10=constant 4.
- result_src  output  2  00=ALUOut, 01=Data, 10=ALUResult.
- alu_control  output  ALUCTL_W  00=ADD, 01=SUB, 10=AND, 11=ORR.
- flags  output  4  registered NZCV.

Behaviour:
- Interface timing: op, funct and cond come from the IR. They are stable from Decode until the instruction's return to FETCH.

Reset:
- State goes to FETCH asynchronously; flags go to 0000; cond_ex_q goes to 0.
- While reset=0, pc_write, ir_write, reg_write and mem_write are forced to 0.
- While reset=0, the mux selects take their FETCH values.
- Reset mid-instruction abandons the instruction; there are no partial writes after reset asserts.

Outputs:
- Moore-decoded from state, then gated by cond_ex_q where stated.
- Unlisted selects are 0; alu_control is 00 unless stated.

States, outputs and transitions:
- FETCH: adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10, ir_write=1, pc_write=1. Next: DECODE.
- DECODE: alu_src_a=1, alu_src_b=10, result_src=10. Latch cond_ex_q = condcheck(cond, flags). Next:
  - op=01 -> MEMADR
  - op=00 & funct[5]=0 -> EXECR
  - op=00 & funct[5]=1 -> EXECI
  - op=10 -> BRANCH
  - op=11 -> FETCH (undefined instruction, treated as a NOP)
- MEMADR: alu_src_b=01. Next: MEMREAD if funct[0]=1, else MEMWRITE.
- MEMREAD: adr_src=1. Next: MEMWB.
- MEMWB: result_src=01, reg_write=cond_ex_q. Next: FETCH.
- MEMWRITE: adr_src=1, mem_write=cond_ex_q. Next: FETCH.
- EXECR: alu_src_b=00, alu_control decoded from cmd. Next: ALUWB.
- EXECI: alu_src_b=01, alu_control decoded from cmd. Next: ALUWB.
- ALUWB: result_src=00, reg_write = cond_ex_q & ~no_write. no_write is set for cmd=1010 (CMP). Next: FETCH.
- BRANCH: alu_src_b=01, result_src=10, pc_write=cond_ex_q. Next: FETCH.

cmd decode:
- 0100 -> ADD
- 0010 -> SUB
- 1010 -> SUB
- 0000 -> AND
- 1100 -> ORR
- any other cmd -> ADD, and reg_write still allowed.

Flags:
- Update at the rising edge ending EXECR/EXECI, only when funct[0]=1 and cond_ex_q=1.
- N,Z are always loaded from alu_flags[3:2].
- C,V are loaded from alu_flags[1:0] only for ADD/SUB/CMP; they are held for AND/ORR.

condcheck:
- 0000 EQ: Z
- 0001 NE: ~Z
- 0010 CS: C
- 0011 CC: ~C
- 0100 MI: N
- 0101 PL: ~N
- 0110 VS: V
- 0111 VC: ~V
- 1000 HI: C&~Z
- 1001 LS: ~C|Z
- 1010 GE: N==V
- 1011 LT: N!=V
- 1100 GT: ~Z&(N==V)
- 1101 LE: Z|(N!=V)
- 1110 AL: 1
- 1111: 0

Latency per instruction class (cycles):
- LDR: 5
- STR: 4
- Data processing: 4
- Branch: 3
- Undefined: 2

Decomposition:
- Package mc_ctrl_pkg:
  - state enum (FETCH..BRANCH, 4-bit)
  - condition code constants
  - cmd constants (ADD/SUB/AND/ORR/CMP)
  - alu_control encodings
  - alu_src_b encodings
  - result_src encodings
- Sub-module cond_unit:
  - flags register
  - condcheck combinational logic
  - flag-write enable logic (NZ/CV split)
  - outputs cond_ex for DECODE and flags.
- Top level: state register, next-state logic, output decode.

Test Plan:
- Reset: hold reset=0 3 cycles, then release -> flags=0000 and all strobes 0 during reset; first post-reset cycle has ir_write=1, pc_write=1, alu_src_b=10, result_src=10.
- LDR (op=01, funct=011001, cond=1110) -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; adr_src=1 in MEMREAD only; reg_write=1 only in MEMWB with result_src=01.
- STR EQ (op=01, funct=011000, cond=0000, flags Z=0) -> 4-cycle sequence ends in MEMWRITE; mem_write stays 0 throughout. Repeat with Z=1 -> mem_write=1 for exactly 1 cycle.
- SUBS (op=00, funct=000101, cond=1110, alu_flags=0110 in EXECR):
  - alu_control=01 in EXECR; flags=0110 from the ALUWB cycle; reg_write=1 in ALUWB.
  - Then ANDS with alu_flags=1011 -> flags=1010 (C,V held).
- CMP immediate (funct=110101) -> EXECI with alu_src_b=01, alu_control=01; ALUWB has reg_write=0; flags updated.
- Branch NE (op=10, cond=0001):
  - Z=1 -> pc_write=0 in BRANCH; Z=0 -> pc_write=1; 3-cycle sequence.
  - Pull reset low mid-MEMREAD of an LDR -> state=FETCH immediately; no reg_write ever pulses for that LDR.
